// File: rtl/uart_pkg.sv
// Shared UART timing definitions: controller states, divider/acquisition limits
// and the acquisitions-per-bit clamp.
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MIN_DIVISOR     = 2;
  localparam int MIN_ACQ_PER_BIT = 4;

  function automatic logic [3:0] clamp_acq(input logic [3:0] n);
    return (n < 4'(MIN_ACQ_PER_BIT)) ? 4'(MIN_ACQ_PER_BIT) : n;
  endfunction

endpackage

// File: rtl/baud_frac_divider.sv
// Fractional clock divider: integer period plus a 1/16-unit accumulator whose
// carry stretches the following period by one clock. Produces the acquisition strobe.
module baud_frac_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  input  logic [3:0]       frac,
  output logic             tc,
  output logic             acq_sig
);

  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       acc;
  logic             carry;
  logic [DIV_W:0]   period_m1;
  logic [4:0]       acc_sum;

  // One bit wider than the divisor so the maximum divisor plus carry cannot wrap
  assign period_m1 = {1'b0, div} + {{DIV_W{1'b0}}, carry} - (DIV_W + 1)'(1);
  assign tc        = !clr && ({1'b0, div_cnt} == period_m1);
  assign acc_sum   = {1'b0, acc} + {1'b0, frac};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div_cnt <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      acq_sig <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      acc     <= acc_sum[3:0];
      carry   <= acc_sum[4];
      acq_sig <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      acq_sig <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_acq_generator.sv
// UART baud timing source: run/idle control, configuration latch, acquisition
// strobe via the fractional divider and the once-per-bit baud strobe.
module baud_acq_generator
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_Enable_i,
  input  logic             p_Restart_i,
  input  logic [DIV_W-1:0] Divisor_i,
  input  logic [3:0]       Fraction_i,
  input  logic [3:0]       AcqNumPerBit_i,
  output logic             AcqSig_o,
  output logic             p_BaudSig_o,
  output logic             p_ConfigError_o
);

  state_t           state, state_nxt;
  logic             clr, latch, err_nxt, div_bad, tc;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       frac_q, n_q, acq_cnt;

  assign div_bad = Divisor_i < DIV_W'(MIN_DIVISOR);

  always_comb begin
    state_nxt = state;
    clr       = 1'b1;
    latch     = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        err_nxt = p_Enable_i && div_bad;
        if (p_Enable_i && !div_bad) begin
          state_nxt = RUN;
          latch     = 1'b1;
        end
      end
      RUN: begin
        if (!p_Enable_i) begin
          state_nxt = IDLE;
        end else if (p_Restart_i) begin
          // Restart overrides any terminal count on the same edge
          if (div_bad) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end else begin
            latch = 1'b1;
          end
        end else begin
          clr = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      p_ConfigError_o <= 1'b0;
    end else begin
      state           <= state_nxt;
      p_ConfigError_o <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      div_q  <= Divisor_i;
      frac_q <= Fraction_i;
      n_q    <= clamp_acq(AcqNumPerBit_i);
    end
  end

  baud_frac_divider #(.DIV_W(DIV_W)) u_div (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .div     (div_q),
    .frac    (frac_q),
    .tc      (tc),
    .acq_sig (AcqSig_o)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acq_cnt     <= '0;
      p_BaudSig_o <= 1'b0;
    end else if (tc) begin
      if (acq_cnt == n_q - 4'd1) begin
        acq_cnt     <= '0;
        p_BaudSig_o <= 1'b1;
      end else begin
        acq_cnt     <= acq_cnt + 4'd1;
        p_BaudSig_o <= 1'b0;
      end
    end else begin
      p_BaudSig_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_acq_generator.sv
// Randomized bench for baud_acq_generator against a strobe-schedule reference model.
module tb_baud_acq_generator;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             rs = 1'b0;
  logic [DIV_W-1:0] div = 8'd10;
  logic [3:0]       frac = 4'd0;
  logic [3:0]       n = 4'd4;
  logic             acq, baud, cerr;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  // Reference model: strobe j after a start at edge e lands on edge
  // e + j*Div + floor((j-1)*Frac/16); every N-th strobe is also a bit strobe.
  bit     m_run = 1'b0;
  longint m_e = 0;
  longint m_j = 1;
  int     m_ld = 0, m_lf = 0, m_ln = 4;
  bit     e_acq = 1'b0, e_baud = 1'b0, e_err = 1'b0;

  baud_acq_generator #(.DIV_W(DIV_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .p_Enable_i      (en),
    .p_Restart_i     (rs),
    .Divisor_i       (div),
    .Fraction_i      (frac),
    .AcqNumPerBit_i  (n),
    .AcqSig_o        (acq),
    .p_BaudSig_o     (baud),
    .p_ConfigError_o (cerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic longint next_t();
    return m_e + m_j * longint'(m_ld) + ((m_j - 1) * longint'(m_lf)) / 16;
  endfunction

  task automatic m_start();
    m_run = 1'b1;
    m_e   = cyc;
    m_j   = 1;
    m_ld  = int'(div);
    m_lf  = int'(frac);
    m_ln  = (int'(n) < 4) ? 4 : int'(n);
  endtask

  task automatic model_edge();
    e_acq  = 1'b0;
    e_baud = 1'b0;
    e_err  = 1'b0;
    if (rst) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (en && int'(div) >= 2) m_start();
      else e_err = en;
    end else if (!en) begin
      m_run = 1'b0;
    end else if (rs) begin
      if (int'(div) < 2) begin
        m_run = 1'b0;
        e_err = 1'b1;
      end else begin
        m_start();
      end
    end else if (cyc == next_t()) begin
      e_acq  = 1'b1;
      e_baud = ((m_j % longint'(m_ln)) == 0);
      m_j++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    model_edge();
    chk("acq", longint'(acq), longint'(e_acq));
    chk("baud", longint'(baud), longint'(e_baud));
    chk("cfg_err", longint'(cerr), longint'(e_err));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic reenable(input int d, input int f, input int nn, input int cycles);
    en = 1'b0;
    tick();
    div  = DIV_W'(d);
    frac = 4'(f);
    n    = 4'(nn);
    en   = 1'b1;
    run(cycles);
  endtask

  initial begin
    rst = 1'b1;
    run(3);
    rst = 1'b0;

    reenable(10, 0, 4, 200);
    reenable(10, 8, 4, 200);
    reenable(3, 1, 5, 250);
    reenable(int'($urandom_range(2, 6)), int'($urandom_range(0, 15)), 2, 200);

    // Config error: stays idle while divisor is illegal, then recovers
    reenable(1, 0, 4, 12);
    div = 8'd5;
    run(40);

    // Config change in RUN has no effect until restart
    div = 8'd3;
    run(30);
    rs = 1'b1;
    tick();
    rs = 1'b0;
    run(30);

    // Restart coincident with terminal count, then mid-period
    for (int k = 0; k < 6; k++) begin
      while (next_t() != cyc + 1) tick();
      rs = 1'b1;
      tick();
      rs = 1'b0;
      run(int'($urandom_range(1, 4)));
      rs = 1'b1;
      tick();
      rs = 1'b0;
      run(7);
    end

    // Restart with illegal divisor drops to idle with error
    div = 8'd0;
    rs  = 1'b1;
    tick();
    rs  = 1'b0;
    run(5);
    div = 8'd4;
    run(30);

    // Reset mid-RUN, then re-enable
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(40);

    // Maximum divisor with carry
    reenable(255, 15, 4, 1600);

    // Randomized mix
    for (int i = 0; i < 5000; i++) begin
      int r;
      r   = int'($urandom_range(0, 999));
      rst = (r < 3);
      en  = !(r >= 3 && r < 13);
      rs  = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 19) == 0)
        div = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom_range(0, 1))
                                          : DIV_W'($urandom_range(2, 12));
      if ($urandom_range(0, 19) == 0) frac = 4'($urandom);
      if ($urandom_range(0, 19) == 0) n = 4'($urandom);
      if ((i % 97) == 0 && m_run && en && !rst && next_t() == cyc + 1) rs = 1'b1;
      tick();
    end
    rst = 1'b0;
    rs  = 1'b0;
    en  = 1'b0;
    run(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/baud_acq_generator.md
# baud_acq_generator

Timing source for the UART receive and transmit paths: divides the system clock into the acquisition strobe `AcqSig_o` that the receive core samples `Rx_i` with, and into the one-per-bit `p_BaudSig_o` used by the transmit path. The divider has an integer part and a 4-bit fractional part (1/16 clock units) so non-integer clock/baud ratios average out exactly. It sits directly upstream of the receive core, which consumes `AcqSig_o`. The receive core must be fed the same `AcqNumPerBit` value as this block.

## Interface
- `DIV_W`, default 16: width of the integer divisor.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous reset, active-high.
- `p_Enable_i`  in  1  run request; low forces IDLE.
- `p_Restart_i`  in  1  one-cycle phase resynchronisation request, for example at Tx frame start.
- `Divisor_i`  in  DIV_W  integer clocks per acquisition period; legal values are 2 or more.
- `Fraction_i`  in  4  fractional clocks per acquisition, in units of 1/16.
- `AcqNumPerBit_i`  in  4  acquisitions per bit; values below 4 are treated as 4.
- `AcqSig_o`  out  1  one-cycle acquisition strobe.
- `p_BaudSig_o`  out  1  one-cycle bit strobe, coincident with every N-th `AcqSig_o`.
- `p_ConfigError_o`  out  1  high while enabled with `Divisor_i` < 2.

## Operation
- States are IDLE and RUN.
- **IDLE:**
  - All counters are 0 and the fractional accumulator is 0.
  - Strobes are low.
  - IDLE → RUN on the edge sampling `p_Enable_i`=1 with `Divisor_i` ≥ 2.
  - If `p_Enable_i`=1 with `Divisor_i` < 2: stay IDLE and set `p_ConfigError_o`=1. The flag is registered and clears on the edge after either condition goes away.
- **Config latch:** `Divisor_i`, `Fraction_i` and the clamped `AcqNumPerBit_i` are latched on IDLE→RUN and on every accepted restart. Changes while in RUN have no effect until the next latch.
- **RUN, divider:**
  - `DivCnt` increments each cycle.
  - When `DivCnt` = period−1: assert `AcqSig_o` for the next cycle and set `DivCnt` to 0.
  - The period is latched Div + `carry`.
  - On each strobe, {`carry`, `acc`} = `acc` + latched Fraction, using 4-bit `acc` and a 1-bit `carry`. The carry lengthens the following period by one clock.
- **RUN, bit counter:**
  - `AcqCnt` counts strobes from 0 to N−1 and wraps.
  - The strobe that wraps it (the N-th) also asserts `p_BaudSig_o` in the same cycle.
- **Restart:**
  - `p_Restart_i`=1 in RUN clears `DivCnt`, `AcqCnt`, `acc` and `carry`, and re-latches config.
  - Neither strobe is asserted in the cycle after an accepted restart.
  - If restart and a terminal count land on the same edge, restart wins and that strobe is dropped.
  - If the sampled `Divisor_i` < 2, the block goes to IDLE instead of re-latching, and `p_ConfigError_o` is set.
  - `p_Restart_i` has no effect in IDLE.
- **Disable:** `p_Enable_i`=0 moves the block to IDLE on the next edge. Strobes are low from the cycle after that edge; there is no partial-period flush.
- **Reset:** all outputs are 0, state is IDLE, and counters and `acc` are 0. Reset mid-RUN behaves the same.
- **Width rules:**
  - `DivCnt` is DIV_W bits.
  - The period compare uses DIV_W+1 bits, so Divisor = 2^DIV_W−1 with carry does not wrap.

## Timing
- Sampling edge at cycle 0 → first `AcqSig_o` high in cycle Div.
- Subsequent strobes are spaced Div or Div+1 cycles apart, following the accumulator.
- Average period is Div + Fraction/16, exact over any 16 consecutive strobes.
- `p_BaudSig_o` period is the sum of N consecutive acquisition periods.
- Both strobes are registered outputs with no combinational path from inputs. Each is exactly one cycle wide.
- Restart edge → next `AcqSig_o` exactly Div cycles later.

## Structure
- **Shared package** (`uart_pkg`):
  - state enum {IDLE, RUN}
  - `MIN_DIVISOR` = 2
  - `MIN_ACQ_PER_BIT` = 4
- **Sub-module** `baud_frac_divider`: `DivCnt`, accumulator, carry and the `AcqSig` strobe, with a clear input.
- **Top level:** FSM, config latch, N clamp, `AcqCnt` and `p_BaudSig_o`.

## Test plan
- **Integer divide:** Div=10, Frac=0, N=4, enable. Expect first `AcqSig_o` 10 cycles after the sampling edge, then every 10 cycles. `p_BaudSig_o` on every 4th strobe, every 40 cycles.
- **Fractional:** Div=10, Frac=8. Expect strobe spacings 10, 10, 11, 10, 11, … averaging 10.5. With Frac=1, exactly one period of 11 in every 16 strobes.
- **Clamp and config error:** N=2 → `p_BaudSig_o` on every 4th strobe. Divisor=1 with enable → stays IDLE, no strobes, `p_ConfigError_o`=1; with Divisor=5 it clears and runs.
- **Restart:**
  - Restart mid-period: next strobe exactly Div cycles later and `AcqCnt` reset, so `p_BaudSig_o` comes N strobes later.
  - Restart coinciding with a terminal count: that strobe is suppressed.
- **Config change and disable:** change `Divisor_i` in RUN → spacing unchanged until a restart. Drop `p_Enable_i` → strobes stop from the cycle after the sampling edge.
- **Reset mid-RUN:** `rst` pulse → all outputs 0 and IDLE. Re-enable → first strobe Div cycles after the sampling edge.
